// File: rtl/line_burst_pkg.sv
// Shared types and constants for the line-to-burst adapter.
// A 256-bit line is moved as four 64-bit beats.
package line_burst_pkg;

  localparam int unsigned BEATS       = 4;
  localparam int unsigned BEAT_IDX_W  = 2;
  localparam int unsigned OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    StIdle,
    StRdBurst,
    StRdDone,
    StWrBurst,
    StWrDone
  } state_e;

endpackage

// File: rtl/line_burst_adapter_if.sv
// Upstream line port plus downstream burst port of the line burst adapter.
// The master modport is the environment; the slave modport is the adapter itself.
interface line_burst_adapter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64
);

  logic                  line_read;
  logic                  line_write;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [LINE_WIDTH-1:0] line_wdata;
  logic [LINE_WIDTH-1:0] line_rdata;
  logic                  line_resp;

  logic                  burst_read;
  logic                  burst_write;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [BEAT_WIDTH-1:0] burst_wdata;
  logic [BEAT_WIDTH-1:0] burst_rdata;
  logic                  burst_resp;

  modport master (
    output line_read, line_write, line_addr, line_wdata, burst_rdata, burst_resp,
    input  line_rdata, line_resp, burst_read, burst_write, burst_addr, burst_wdata
  );

  modport slave (
    input  line_read, line_write, line_addr, line_wdata, burst_rdata, burst_resp,
    output line_rdata, line_resp, burst_read, burst_write, burst_addr, burst_wdata
  );

endinterface

// File: rtl/line_beat_buffer.sv
// Line-wide register written either one beat at a time or as a whole line.
// A full-line load takes priority over a beat write in the same cycle.
module line_beat_buffer
  import line_burst_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BEAT_IDX_W-1:0] idx,
  input  logic [BEAT_WIDTH-1:0] beat_in,
  input  logic                  line_load,
  input  logic [LINE_WIDTH-1:0] line_in,
  output logic [LINE_WIDTH-1:0] line_out
);

  logic [LINE_WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (line_load) begin
      data_d = line_in;
    end else if (load) begin
      for (int k = 0; k < BEATS; k++) begin
        if (idx == BEAT_IDX_W'(k)) begin
          data_d[k*BEAT_WIDTH +: BEAT_WIDTH] = beat_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign line_out = data_q;

endmodule

// File: rtl/line_burst_reg.sv
// Generic enabled register with synchronous active-high clear.
module line_burst_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/line_burst_adapter.sv
// Turns single-beat line reads/writes into 4-beat memory bursts and reassembles read bursts.
// One line transaction is in flight at a time.
module line_burst_adapter
  import line_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64
) (
  input logic                 clk,
  input logic                 rst,
  line_burst_adapter_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] AlignMask =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  state_e                state_q, state_d;
  logic [BEAT_IDX_W-1:0] cnt_q, cnt_d;
  logic                  accept_rd, accept_wr;
  logic                  rd_beat;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] rd_line, wr_line, rdata_q;
  logic [BEAT_WIDTH-1:0] wr_beat;

  // Read has priority when both requests are raised together.
  assign accept_rd = (state_q == StIdle) && bus.line_read;
  assign accept_wr = (state_q == StIdle) && !bus.line_read && bus.line_write;
  assign rd_beat   = (state_q == StRdBurst) && bus.burst_resp;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.line_read) begin
          state_d = StRdBurst;
          cnt_d   = '0;
        end else if (bus.line_write) begin
          state_d = StWrBurst;
          cnt_d   = '0;
        end
      end
      StRdBurst: begin
        if (bus.burst_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BEAT_IDX_W'(BEATS - 1)) begin
            state_d = StRdDone;
          end
        end
      end
      StWrBurst: begin
        if (bus.burst_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BEAT_IDX_W'(BEATS - 1)) begin
            state_d = StWrDone;
          end
        end
      end
      StRdDone: state_d = StIdle;
      StWrDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  line_burst_reg #(
    .WIDTH(ADDR_WIDTH)
  ) u_addr_reg (
    .clk (clk),
    .rst (rst),
    .en  (accept_rd || accept_wr),
    .d   (bus.line_addr & AlignMask),
    .q   (addr_q)
  );

  line_beat_buffer #(
    .LINE_WIDTH(LINE_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH)
  ) u_rd_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (rd_beat),
    .idx       (cnt_q),
    .beat_in   (bus.burst_rdata),
    .line_load (1'b0),
    .line_in   ('0),
    .line_out  (rd_line)
  );

  line_beat_buffer #(
    .LINE_WIDTH(LINE_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH)
  ) u_wr_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .idx       (cnt_q),
    .beat_in   ('0),
    .line_load (accept_wr),
    .line_in   (bus.line_wdata),
    .line_out  (wr_line)
  );

  // Keeps the last completed line visible while the next read assembles in u_rd_buf.
  line_burst_reg #(
    .WIDTH(LINE_WIDTH)
  ) u_rdata_reg (
    .clk (clk),
    .rst (rst),
    .en  (state_q == StRdDone),
    .d   (rd_line),
    .q   (rdata_q)
  );

  always_comb begin
    wr_beat = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == BEAT_IDX_W'(k)) begin
        wr_beat = wr_line[k*BEAT_WIDTH +: BEAT_WIDTH];
      end
    end
  end

  always_comb begin
    bus.burst_read  = (state_q == StRdBurst);
    bus.burst_write = (state_q == StWrBurst);
    bus.burst_addr  = addr_q;
    bus.burst_wdata = (state_q == StWrBurst) ? wr_beat : '0;
    bus.line_resp   = (state_q == StRdDone) || (state_q == StWrDone);
    bus.line_rdata  = (state_q == StRdDone) ? rd_line : rdata_q;
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Scoreboard bench for line_burst_adapter: a driver issues randomized line transactions and
// acts as memory; a negedge monitor compares DUT outputs against queued expectations.
module tb_line_burst_adapter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam int unsigned BW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_burst_adapter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW)) bus ();

  line_burst_adapter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit           is_wr;
    bit           abort;
    logic [31:0]  addr;
    logic [255:0] line;
    int           cycles;
  } txn_t;

  txn_t         exp_q[$];
  txn_t         mon_t;
  int           checks = 0;
  int           errors = 0;
  logic [255:0] last_line = '0;
  int           wcnt = 0;
  int           bcyc = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every expectation comes from the queued transaction record.
  always @(negedge clk) begin
    if (rst) begin
      if (exp_q.size() > 0 && exp_q[0].abort) void'(exp_q.pop_front());
      wcnt      = 0;
      bcyc      = 0;
      last_line = '0;
    end else begin
      if (bus.burst_read || bus.burst_write) begin
        bcyc++;
        if (exp_q.size() == 0) begin
          chk("burst_without_txn", 256'({bus.burst_write, bus.burst_read}), 256'(0));
        end else begin
          chk("burst_op", 256'({bus.burst_write, bus.burst_read}),
              exp_q[0].is_wr ? 256'(2) : 256'(1));
          chk("burst_addr", 256'(bus.burst_addr), 256'(exp_q[0].addr));
          if (bus.burst_write && bus.burst_resp && wcnt < 4) begin
            chk("burst_wdata", 256'(bus.burst_wdata), 256'(exp_q[0].line[wcnt*64 +: 64]));
            wcnt++;
          end
        end
      end
      if (bus.line_resp) begin
        if (exp_q.size() == 0 || exp_q[0].abort) begin
          chk("line_resp_unexpected", 256'(bus.line_resp), 256'(0));
        end else begin
          mon_t = exp_q.pop_front();
          chk("burst_cycles", 256'(bcyc), 256'(mon_t.cycles));
          if (mon_t.is_wr) begin
            chk("wr_beats", 256'(wcnt), 256'(4));
            chk("rdata_kept_by_write", bus.line_rdata, last_line);
          end else begin
            chk("line_rdata", bus.line_rdata, mon_t.line);
            last_line = mon_t.line;
          end
        end
        wcnt = 0;
        bcyc = 0;
      end else begin
        chk("rdata_hold", bus.line_rdata, last_line);
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    chk({name, "_ctl"}, 256'({bus.burst_read, bus.burst_write, bus.line_resp}), 256'(0));
    chk({name, "_rdata"}, bus.line_rdata, 256'(0));
    chk({name, "_addr"}, 256'(bus.burst_addr), 256'(0));
    chk({name, "_wdata"}, 256'(bus.burst_wdata), 256'(0));
  endtask

  // Called #1 after a posedge. gaps[k] idle cycles precede beat k. from_done means the
  // request is being raised in the DONE cycle of the previous transaction.
  task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [255:0] line,
                        input logic [3:0][1:0] gaps, input bit both, input bit hold,
                        input bit from_done, input int abort_after);
    txn_t t;
    int   got;
    int   n;
    t.is_wr  = is_wr;
    t.abort  = (abort_after > 0);
    t.addr   = addr & ~32'h1F;
    t.line   = line;
    t.cycles = 4;
    for (int k = 0; k < 4; k++) t.cycles += int'(gaps[k]);
    exp_q.push_back(t);

    bus.line_addr  = addr;
    bus.line_read  = !is_wr;
    bus.line_write = is_wr || both;
    bus.line_wdata = is_wr ? line : rand256();
    got = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (bus.burst_read || bus.burst_write) begin
        got = i;
        break;
      end
    end
    chk("accept_latency", 256'(got), from_done ? 256'(2) : 256'(1));
    if (got == 0) $fatal(1, "accept timeout");

    // Inputs latched at acceptance; churn them to prove they are ignored mid-burst.
    bus.line_addr  = $urandom;
    bus.line_wdata = rand256();
    n = 0;
    while (n < 4) begin
      for (int g = 0; g < int'(gaps[n]); g++) begin
        bus.burst_resp  = 1'b0;
        bus.burst_rdata = rand64();
        @(posedge clk); #1;
      end
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = is_wr ? rand64() : line[n*64 +: 64];
      @(posedge clk); #1;
      n++;
      if (abort_after > 0 && n == abort_after) break;
    end
    bus.burst_resp = 1'b0;

    if (abort_after > 0) begin
      rst            = 1'b1;
      bus.line_read  = 1'b0;
      bus.line_write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check_outputs_zero("abort_reset");
      return;
    end

    chk("line_resp_strobe", 256'(bus.line_resp), 256'(1));
    if (!hold) begin
      bus.line_read  = 1'b0;
      bus.line_write = 1'b0;
      @(posedge clk); #1;
      chk("line_resp_single", 256'(bus.line_resp), 256'(0));
    end
  endtask

  task automatic idle_spurious();
    bus.burst_resp  = 1'b1;
    bus.burst_rdata = rand64();
    bus.line_addr   = $urandom;
    @(posedge clk); #1;
    chk("idle_no_burst", 256'({bus.burst_read, bus.burst_write}), 256'(0));
    bus.burst_resp = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][1:0] g;
    bit              prev_hold;
    bit              is_wr;
    bit              hold;

    rst             = 1'b1;
    bus.line_read   = 1'b0;
    bus.line_write  = 1'b0;
    bus.line_addr   = '0;
    bus.line_wdata  = '0;
    bus.burst_rdata = '0;
    bus.burst_resp  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    g = '0;
    do_txn(1'b0, 32'h0000_1234,
           {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
           g, 1'b0, 1'b0, 1'b0, 0);

    g = '0; g[1] = 2'd1; g[2] = 2'd1;
    do_txn(1'b1, 32'h0000_8040,
           {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
            64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000},
           g, 1'b0, 1'b0, 1'b0, 0);

    g = '0;
    do_txn(1'b0, $urandom, rand256(), g, 1'b1, 1'b0, 1'b0, 0);

    do_txn(1'b0, $urandom, rand256(), g, 1'b0, 1'b0, 1'b0, 2);
    do_txn(1'b0, $urandom, rand256(), g, 1'b0, 1'b0, 1'b0, 0);

    idle_spurious();

    do_txn(1'b0, $urandom, rand256(), g, 1'b0, 1'b1, 1'b0, 0);
    do_txn(1'b1, $urandom, rand256(), g, 1'b0, 1'b0, 1'b1, 0);

    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) g[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      is_wr = $urandom_range(0, 1) == 1;
      hold  = (i < 39) && ($urandom_range(0, 3) == 0);
      do_txn(is_wr, $urandom, rand256(), g, !is_wr && ($urandom_range(0, 3) == 0), hold,
             prev_hold, 0);
      prev_hold = hold;
      if (!hold && $urandom_range(0, 4) == 0) idle_spurious();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
